// File: rtl/regfile_wb_scheduler.sv
// Write-port owner for the 32x32 register file: zero-fill after reset or on request,
// then round-robin arbitration of the ALU (A) and load (B) writeback requesters.
//
// state | meaning
// CLEAR | zero-filling registers 0..NUM_REGS-1, one per cycle; no grants
// RUN   | arbitrating A/B writebacks; clear_req sends us back to CLEAR
module regfile_wb_scheduler #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              init_done,
    output logic              zero_drop
);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              rr_ptr_q, rr_ptr_d;   // 0 = A next in line, 1 = B
    logic              reg_write_d, init_done_d, zero_drop_d;
    logic [ADDR_W-1:0] write_reg_d;
    logic [DATA_W-1:0] write_data_d;
    logic              grant_a, grant_b, run_ok;

    assign grant_a = a_valid && (!b_valid || !rr_ptr_q);
    assign grant_b = b_valid && (!a_valid ||  rr_ptr_q);
    assign run_ok  = (state_q == S_RUN) && !clear_req;
    assign a_ready = grant_a && run_ok;
    assign b_ready = grant_b && run_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_CLEAR;
            clr_cnt_q  <= '0;
            rr_ptr_q   <= 1'b0;
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            init_done  <= 1'b0;
            zero_drop  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            reg_write  <= reg_write_d;
            write_reg  <= write_reg_d;
            write_data <= write_data_d;
            init_done  <= init_done_d;
            zero_drop  <= zero_drop_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg;
        write_data_d = write_data;
        init_done_d  = init_done;
        zero_drop_d  = 1'b0;

        case (state_q)
            S_CLEAR: begin
                reg_write_d  = 1'b1;
                write_reg_d  = clr_cnt_q;
                write_data_d = '0;
                init_done_d  = 1'b0;
                if (clr_cnt_q == LAST_REG) begin
                    state_d     = S_RUN;
                    init_done_d = 1'b1;
                    clr_cnt_d   = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (clear_req) begin
                    state_d     = S_CLEAR;
                    init_done_d = 1'b0;
                    clr_cnt_d   = '0;
                end else if (a_ready) begin
                    // $0 writes are consumed but never reach the register file
                    reg_write_d  = (a_addr != '0);
                    zero_drop_d  = (a_addr == '0);
                    write_reg_d  = a_addr;
                    write_data_d = a_data;
                    rr_ptr_d     = 1'b1;
                end else if (b_ready) begin
                    reg_write_d  = (b_addr != '0);
                    zero_drop_d  = (b_addr == '0);
                    write_reg_d  = b_addr;
                    write_data_d = b_data;
                    rr_ptr_d     = 1'b0;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

endmodule
